check_test_unit: RTL and testbench
==================================

Name: check_test_unit

Overview:
- Synchronous two-input logic checker. Samples single-bit inputs a and b every clock, computes c through a parameterised 2-input truth table, and registers c.
- Keeps saturating per-combination occurrence counters and a coverage flag, so a surrounding bench or debug logic can confirm all four input combinations were exercised.
- Default truth table is AND: c = a & b.

Parameters:
- TT, 4'b1000, truth table; c_next = TT[{a,b}] (index 0 = a0 b0, 1 = a0 b1, 2 = a1 b0, 3 = a1 b1)
- CNT_W, 8, width of each occurrence counter (legal range 1..32)

Ports:
- clk  input  1  single system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- a  input  1  operand A
- b  input  1  operand B
- c  output  1  registered result TT[{a,b}]
- c_toggle  output  1  one-cycle pulse when c changes value
- hist_sel  input  2  selects which combination counter drives hist_cnt
- hist_cnt  output  CNT_W  occurrence count for combination hist_sel
- all_seen  output  1  high once all four combinations have been sampled since reset

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- All state updates on the rising edge of clk only. No combinational path from a or b to any output.
- Reset (rst=1 at an edge) clears c, c_toggle and all four counters to 0; all_seen therefore reads 0. Reset takes priority over every other update, including mid-operation.
- c:
  - c <= TT[{a,b}] every non-reset cycle.
  - Latency is 1 cycle: inputs sampled at edge N appear on c after edge N.
- c_toggle:
  - c_toggle <= (TT[{a,b}] != c) every non-reset cycle.
  - High for exactly the cycle in which the new c differs from its previous value; 0 otherwise.
  - The first update after reset counts as a toggle only if the new c is 1.
- Counters:
  - Four counters cnt[0..3], indexed by {a,b}.
  - Each non-reset edge increments cnt[{a,b}] by 1; exactly one counter increments per cycle.
  - Counters saturate at 2^CNT_W-1 and never wrap; the other three hold.
- hist_cnt:
  - Combinational mux: hist_cnt = cnt[hist_sel]. It reflects counter register contents, so an increment at edge N is visible after edge N.
  - hist_sel may change any cycle without side effects.
- all_seen:
  - all_seen = AND over i of (cnt[i] != 0), derived from counter registers.
  - Asserts in the cycle after the edge that samples the last unseen combination.
  - Stays high until reset; saturation does not clear it.
- X/Z on a or b: no defined requirement. Counters and c need not be protected.

Test Plan:
- Reset then default TT. Apply {a,b} = 00, 01, 10, 11, holding each 1 cycle -> c after each edge = 0, 0, 0, 1. c_toggle pulses only after the 11 sample. all_seen = 1 after the fourth edge and 0 before it.
- After the previous sequence, sweep hist_sel 0..3 -> hist_cnt = 1, 1, 1, 1. Then hold a=1, b=1 for 5 more cycles -> hist_sel=3 reads 6, others still read 1.
- CNT_W=2, hold a=0, b=1 for 6 cycles -> cnt[1] reads 1, 2, 3, 3, 3, 3 (saturates, no wrap). all_seen stays 0.
- TT=4'b0110 (XOR). Apply 00, 01, 10, 11 -> c = 0, 1, 1, 0. c_toggle pulses after the 01 sample and after the 11 sample only.
- Reset mid-operation: after all_seen=1 and c=1, assert rst for one edge with a=1, b=1 -> c=0, c_toggle=0, all counters 0, all_seen=0. The next edge with a=1, b=1 gives c=1, c_toggle=1, cnt[3]=1.
- Back-to-back identical inputs: a=1, b=1 held 3 cycles after reset -> c_toggle high for the first cycle only, then 0 while c stays 1.

Source files
------------

// File: rtl/check_test_unit.sv
// check_test_unit: registered 2-input truth-table checker with saturating per-combination counters and coverage flag
module check_test_unit #(
    parameter logic [3:0] TT    = 4'b1000,
    parameter int         CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             c,
    output logic             c_toggle,
    input  logic [1:0]       hist_sel,
    output logic [CNT_W-1:0] hist_cnt,
    output logic             all_seen
);
    logic [CNT_W-1:0] r_cnt [4];
    logic [1:0]       w_idx;
    logic             w_c;
    assign w_idx = {a, b};
    assign w_c   = TT[w_idx];
    always_ff @(posedge clk) begin
        if (rst) begin
            c        <= 1'b0;
            c_toggle <= 1'b0;
            r_cnt    <= '{default: '0};
        end else begin
            c        <= w_c;
            c_toggle <= w_c != c;
            if (r_cnt[w_idx] != '1) r_cnt[w_idx] <= r_cnt[w_idx] + CNT_W'(1);
        end
    end
    assign hist_cnt = r_cnt[hist_sel];
    assign all_seen = (r_cnt[0] != '0) && (r_cnt[1] != '0) && (r_cnt[2] != '0) && (r_cnt[3] != '0);
endmodule

// File: tb/tb_check_test_unit.sv
// tb_check_test_unit: randomized and directed self-checking bench for check_test_unit
module tb_check_test_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic [1:0] hist_sel = 2'd0;
    logic       c_o [3];
    logic       tg_o [3];
    logic       as_o [3];
    logic [7:0] hc0;
    logic [1:0] hc1;
    logic [7:0] hc2;
    int         tests = 0;
    int         fails = 0;
    bit         started = 1'b0;

    logic [3:0] tts [3] = '{4'b1000, 4'b1000, 4'b0110};
    int         mx  [3] = '{255, 3, 255};
    int         m_cnt [3][4];
    int         m_c [3];
    int         m_tg [3];

    always #5 clk = ~clk;

    check_test_unit u0 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c_o[0]), .c_toggle(tg_o[0]),
                        .hist_sel(hist_sel), .hist_cnt(hc0), .all_seen(as_o[0]));
    check_test_unit #(.TT(4'b1000), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c_o[1]),
                        .c_toggle(tg_o[1]), .hist_sel(hist_sel), .hist_cnt(hc1), .all_seen(as_o[1]));
    check_test_unit #(.TT(4'b0110)) u2 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c_o[2]),
                        .c_toggle(tg_o[2]), .hist_sel(hist_sel), .hist_cnt(hc2), .all_seen(as_o[2]));

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) started <= 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_c[k]  <= 0;
                m_tg[k] <= 0;
                for (int j = 0; j < 4; j++) m_cnt[k][j] <= 0;
            end else begin
                m_c[k]  <= int'(tts[k][{a, b}]);
                m_tg[k] <= int'(tts[k][{a, b}]) != m_c[k] ? 1 : 0;
                if (m_cnt[k][{a, b}] < mx[k]) m_cnt[k][{a, b}] <= m_cnt[k][{a, b}] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("c[%0d]", k), int'(c_o[k]), m_c[k]);
                chk($sformatf("c_toggle[%0d]", k), int'(tg_o[k]), m_tg[k]);
                chk($sformatf("all_seen[%0d]", k), int'(as_o[k]),
                    (m_cnt[k][0] > 0 && m_cnt[k][1] > 0 && m_cnt[k][2] > 0 && m_cnt[k][3] > 0) ? 1 : 0);
            end
            chk("hist_cnt[0]", int'(hc0), m_cnt[0][hist_sel]);
            chk("hist_cnt[1]", int'(hc1), m_cnt[1][hist_sel]);
            chk("hist_cnt[2]", int'(hc2), m_cnt[2][hist_sel]);
        end
    end

    task automatic drive(input logic ia, input logic ib, input logic ir);
        a   = ia;
        b   = ib;
        rst = ir;
        @(posedge clk);
        #2;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b1);
        chk("rst c", int'(c_o[0]), 0);
        chk("rst c_toggle", int'(tg_o[0]), 0);
        chk("rst all_seen", int'(as_o[0]), 0);
        chk("rst hist", int'(hc0), 0);
        drive(1'b0, 1'b0, 1'b0);
        chk("and 00 c", int'(c_o[0]), 0);
        chk("xor 00 c", int'(c_o[2]), 0);
        drive(1'b0, 1'b1, 1'b0);
        chk("and 01 c", int'(c_o[0]), 0);
        chk("xor 01 c", int'(c_o[2]), 1);
        chk("xor 01 tog", int'(tg_o[2]), 1);
        drive(1'b1, 1'b0, 1'b0);
        chk("and 10 c", int'(c_o[0]), 0);
        chk("and 10 all_seen", int'(as_o[0]), 0);
        chk("xor 10 tog", int'(tg_o[2]), 0);
        drive(1'b1, 1'b1, 1'b0);
        chk("and 11 c", int'(c_o[0]), 1);
        chk("and 11 tog", int'(tg_o[0]), 1);
        chk("and 11 all_seen", int'(as_o[0]), 1);
        chk("xor 11 c", int'(c_o[2]), 0);
        chk("xor 11 tog", int'(tg_o[2]), 1);
        for (int s = 0; s < 4; s++) begin
            hist_sel = 2'(s);
            #1;
            chk($sformatf("sweep hist %0d", s), int'(hc0), 1);
        end
        for (int s = 0; s < 5; s++) drive(1'b1, 1'b1, 1'b0);
        chk("hold 11 tog", int'(tg_o[0]), 0);
        for (int s = 0; s < 4; s++) begin
            hist_sel = 2'(s);
            #1;
            chk($sformatf("hold hist %0d", s), int'(hc0), s == 3 ? 6 : 1);
        end
        drive(1'b1, 1'b1, 1'b1);
        chk("midrst c", int'(c_o[0]), 0);
        chk("midrst tog", int'(tg_o[0]), 0);
        chk("midrst all_seen", int'(as_o[0]), 0);
        chk("midrst hist3", int'(hc0), 0);
        drive(1'b1, 1'b1, 1'b0);
        chk("post rst c", int'(c_o[0]), 1);
        chk("post rst tog", int'(tg_o[0]), 1);
        chk("post rst hist3", int'(hc0), 1);
        drive(1'b1, 1'b1, 1'b0);
        chk("b2b tog 2", int'(tg_o[0]), 0);
        drive(1'b1, 1'b1, 1'b0);
        chk("b2b tog 3", int'(tg_o[0]), 0);
        chk("b2b c 3", int'(c_o[0]), 1);
        drive(1'b0, 1'b0, 1'b1);
        hist_sel = 2'd1;
        for (int s = 0; s < 6; s++) begin
            drive(1'b0, 1'b1, 1'b0);
            chk($sformatf("sat cnt %0d", s), int'(hc1), s < 3 ? s + 1 : 3);
            chk($sformatf("sat all_seen %0d", s), int'(as_o[1]), 0);
        end
        for (int s = 0; s < 3000; s++) begin
            hist_sel = 2'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 60) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected end before 1000000");
        $fatal(1);
    end
endmodule
